// File: rtl/pace_pkg.sv
// Shared constants and helpers for the decade pace chain.
package pace_pkg;

   localparam int unsigned BCD_W          = 4;
   localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;
   localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;

   // Wraps on anything >= 9 so a digit can never leave the BCD range.
   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
      return (d >= BCD_MAX) ? '0 : d + 1'b1;
   endfunction

endpackage

// File: rtl/bcd_decade_counter.sv
// Single divide-by-10 BCD stage with synchronous clear and combinational carry.
module bcd_decade_counter
   import pace_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [BCD_W-1:0] digit,
   output logic             carry
);

   logic [BCD_W-1:0] digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = '0;
      end else if (en) begin
         digit_d = bcd_inc(digit_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;
   assign carry = en & ~clr & (digit_q == BCD_MAX);

endmodule

// File: rtl/pace_decade_chain.sv
// Prescaler producing a base-rate tick followed by a cascade of BCD decade counters.
module pace_decade_chain
   import pace_pkg::*;
#(
   parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
   parameter int unsigned BASE_HZ     = 10,
   parameter int unsigned NUM_DECADES = 4
) (
   input  logic                         clk,
   input  logic                         reStart,
   input  logic                         run,
   input  logic                         reSync,
   output logic [NUM_DECADES:0]         tick,
   output logic [BCD_W*NUM_DECADES-1:0] digits,
   output logic                         rollover
);

   localparam int unsigned DIVISOR = (BASE_HZ == 0) ? 0 : CLK_HZ / BASE_HZ;
   localparam int unsigned PRE_W   = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
   localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(DIVISOR - 1);

   if (BASE_HZ == 0 || (CLK_HZ % BASE_HZ) != 0) begin : g_bad_ratio
      $error("pace_decade_chain: CLK_HZ must be an exact multiple of BASE_HZ");
   end
   if (DIVISOR < 2) begin : g_bad_divisor
      $error("pace_decade_chain: CLK_HZ/BASE_HZ must be at least 2");
   end
   if (NUM_DECADES < 1 || NUM_DECADES > 8) begin : g_bad_decades
      $error("pace_decade_chain: NUM_DECADES must be in 1..8");
   end

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             adv;

   assign adv = run & ~reSync;

   always_comb begin
      pre_d = pre_q;
      if (reSync) begin
         pre_d = PRE_LOAD;
      end else if (run) begin
         pre_d = (pre_q == '0) ? PRE_LOAD : pre_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reStart) begin
      if (reStart) begin
         pre_q <= PRE_LOAD;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign tick[0] = adv & (pre_q == '0);

   // Each stage's carry is the next stage's enable, so a full carry ripples in one cycle.
   for (genvar k = 0; k < NUM_DECADES; k++) begin : g_decade
      bcd_decade_counter u_decade (
         .clk   (clk),
         .rst   (reStart),
         .clr   (reSync),
         .en    (tick[k]),
         .digit (digits[BCD_W*k +: BCD_W]),
         .carry (tick[k+1])
      );
   end

   assign rollover = tick[NUM_DECADES];

endmodule

// File: tb/tb_pace_decade_chain.sv
// Randomized and directed bench for pace_decade_chain against an arithmetic reference model.
module tb_pace_decade_chain;

   localparam int unsigned CLK_HZ = 100;
   localparam int unsigned BASE_HZ = 10;
   localparam int unsigned N = 2;
   localparam int unsigned DIV = CLK_HZ / BASE_HZ;
   localparam int unsigned NT = N + 1;
   localparam int unsigned NW = 4 * N;

   logic          clk = 1'b0;
   logic          reStart;
   logic          run;
   logic          reSync;
   logic [NT-1:0] tick;
   logic [NW-1:0] digits;
   logic          rollover;

   int checks = 0;
   int failures = 0;

   // Model state: enabled cycles elapsed in the current period, and the decimal count.
   int p = 0;
   int val = 0;
   int modulus = 100;
   logic [NT-1:0] prev_tick = '0;

   logic [NT-1:0] s_tick;
   logic [NW-1:0] s_dig;
   logic          s_roll;

   pace_decade_chain #(
      .CLK_HZ      (CLK_HZ),
      .BASE_HZ     (BASE_HZ),
      .NUM_DECADES (N)
   ) u_dut (
      .clk      (clk),
      .reStart  (reStart),
      .run      (run),
      .reSync   (reSync),
      .tick     (tick),
      .digits   (digits),
      .rollover (rollover)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      p = 0;
      val = 0;
      prev_tick = '0;
   endtask

   // Entered just after a rising edge; drives inputs, samples mid-cycle, advances the model.
   task automatic cycle(input logic r, input logic s);
      logic [NT-1:0] et;
      logic [NW-1:0] ed;
      int pw;
      run = r;
      reSync = s;
      #3;
      s_tick = tick;
      s_dig = digits;
      s_roll = rollover;
      et = '0;
      if (r && !s && p == DIV - 1) begin
         et[0] = 1'b1;
         pw = 1;
         for (int k = 1; k <= N; k++) begin
            pw = pw * 10;
            et[k] = ((val % pw) == pw - 1);
         end
      end
      ed = '0;
      pw = 1;
      for (int k = 0; k < N; k++) begin
         ed[4*k +: 4] = 4'((val / pw) % 10);
         pw = pw * 10;
      end
      check("tick", 32'(s_tick), 32'(et));
      check("digits", 32'(s_dig), 32'(ed));
      check("rollover", 32'(s_roll), 32'(et[N]));
      for (int k = 0; k < N; k++) begin
         check("bcd_range", 32'(s_dig[4*k +: 4] <= 4'd9), 32'd1);
      end
      check("tick_width", 32'(s_tick & prev_tick), 32'd0);
      prev_tick = s_tick;
      @(posedge clk);
      if (s) begin
         p = 0;
         val = 0;
      end else if (r) begin
         if (p == DIV - 1) begin
            p = 0;
            val = (val + 1) % modulus;
         end else begin
            p++;
         end
      end
      #1;
   endtask

   initial begin
      logic [NW-1:0] held;
      int budget;
      reStart = 1'b1;
      run = 1'b0;
      reSync = 1'b0;
      #2;
      check("reset_tick", 32'(tick), 32'd0);
      check("reset_digits", 32'(digits), 32'd0);
      check("reset_roll", 32'(rollover), 32'd0);
      run = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold_tick", 32'(tick), 32'd0);
      check("reset_hold_digits", 32'(digits), 32'd0);
      reStart = 1'b0;
      model_reset();

      // Full wrap from release: tick[0] every 10, tick[1] every 100, rollover at 999.
      for (int c = 0; c <= 1000; c++) begin
         cycle(1'b1, 1'b0);
         check("wrap_tick0", 32'(s_tick[0]), 32'(c % 10 == 9));
         check("wrap_tick1", 32'(s_tick[1]), 32'(c % 100 == 99));
         check("wrap_roll", 32'(s_roll), 32'(c == 999));
         if (c == 9) check("wrap_dig9", 32'(s_dig), 32'h00);
         if (c == 10) check("wrap_dig10", 32'(s_dig), 32'h01);
         if (c == 20) check("wrap_dig20", 32'(s_dig), 32'h02);
         if (c == 999) check("wrap_dig999", 32'(s_dig), 32'h99);
         if (c == 1000) check("wrap_dig1000", 32'(s_dig), 32'h00);
      end

      // Pause for 20 cycles starting at cycle 5.
      cycle(1'b1, 1'b1);
      held = '0;
      for (int c = 0; c < 40; c++) begin
         cycle(!(c >= 5 && c < 25), 1'b0);
         if (c == 5) held = s_dig;
         if (c >= 5 && c < 25) begin
            check("pause_tick", 32'(s_tick), 32'd0);
            check("pause_digits", 32'(s_dig), 32'(held));
         end
         if (c >= 25 && c <= 29) check("resume_tick0", 32'(s_tick[0]), 32'(c == 29));
      end

      // reSync coincident with the expiring prescaler.
      cycle(1'b1, 1'b1);
      for (int c = 0; c < 20; c++) begin
         cycle(1'b1, c == 9);
         if (c == 9) begin
            check("sync_tick0", 32'(s_tick[0]), 32'd0);
            check("sync_digits", 32'(s_dig), 32'h00);
         end
         if (c >= 10) check("sync_next_tick0", 32'(s_tick[0]), 32'(c == 19));
      end
      check("sync_after_dig", 32'(digits), 32'h01);

      // Asynchronous reset mid-cycle once the count reaches 59.
      budget = 2000;
      while (!(val == 59 && p == 5) && budget > 0) begin
         cycle(1'b1, 1'b0);
         budget--;
      end
      check("reach59_budget", 32'(budget > 0), 32'd1);
      check("pre_reset_dig", 32'(digits), 32'h59);
      #2;
      reStart = 1'b1;
      #1;
      check("async_tick", 32'(tick), 32'd0);
      check("async_digits", 32'(digits), 32'd0);
      check("async_roll", 32'(rollover), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("async_hold_digits", 32'(digits), 32'd0);
      reStart = 1'b0;
      model_reset();
      for (int c = 0; c < 21; c++) begin
         cycle(1'b1, 1'b0);
         check("rel_tick0", 32'(s_tick[0]), 32'(c % 10 == 9));
         if (c == 10) check("rel_dig10", 32'(s_dig), 32'h01);
         if (c == 20) check("rel_dig20", 32'(s_dig), 32'h02);
      end

      // Random run/reSync against the model.
      for (int c = 0; c < 20000; c++) begin
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 2999) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
